// File: rtl/coin_input_conditioner.sv
// Coin button conditioner: 2-flop sync, per-channel debounce, rising-edge capture and a
// Q > D > N priority arbiter with post-pulse lockout. Define COIN_TALLY_EN to add the Tally port.
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 2
) (
  input  logic       ClkIn,
  input  logic       Reset,
  input  logic       BN,
  input  logic       BD,
  input  logic       BQ,
  output logic       N,
  output logic       D,
  output logic       Q,
`ifdef COIN_TALLY_EN
  output logic       Busy,
  output logic [7:0] Tally
`else
  output logic       Busy
`endif
);

  typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} state_t;

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] LOCK_LAST = 4'(LOCKOUT_CYCLES - 1);

  // Channel index 0 = nickel, 1 = dime, 2 = quarter.
  logic [2:0] raw;
  logic [2:0] sync1, sync2;
  logic [2:0] level, level_next;
  logic [2:0] rise;
  logic [2:0] pending, pending_next;
  logic [3:0] db_cnt [3];
  logic [3:0] db_cnt_next [3];

  state_t     state, state_next;
  logic [2:0] grant;
  logic [2:0] outs, outs_next;
  logic [3:0] lock_cnt, lock_next;

  assign raw = {BQ, BD, BN};

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_next = level;
    for (int ch = 0; ch < 3; ch++) begin
      db_cnt_next[ch] = '0;
      if (sync2[ch] != level[ch]) begin
        if (db_cnt[ch] == DB_LAST) begin
          level_next[ch] = sync2[ch];
        end else begin
          db_cnt_next[ch] = db_cnt[ch] + 4'd1;
        end
      end
    end
  end

  assign rise = level_next & ~level;

  always_comb begin
    state_next = state;
    grant      = '0;
    outs_next  = '0;
    lock_next  = lock_cnt;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          if (pending[2])      grant = 3'b100;
          else if (pending[1]) grant = 3'b010;
          else                 grant = 3'b001;
          outs_next  = grant;
          state_next = PULSE;
        end
      end
      PULSE: begin
        if (LOCKOUT_CYCLES == 0) begin
          state_next = IDLE;
        end else begin
          state_next = LOCKOUT;
          lock_next  = LOCK_LAST;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == 4'd0) state_next = IDLE;
        else                  lock_next  = lock_cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh press on a channel wins over the clear of that same channel's grant.
  assign pending_next = (pending & ~grant) | rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ClkIn) begin
    if (!Reset) begin
      sync1    <= '0;
      sync2    <= '0;
      level    <= '0;
      pending  <= '0;
      state    <= IDLE;
      outs     <= '0;
      lock_cnt <= '0;
      // NOTE: this small counter array is reset element by element; it is flops, not a RAM.
      for (int ch = 0; ch < 3; ch++) db_cnt[ch] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      level    <= level_next;
      pending  <= pending_next;
      state    <= state_next;
      outs     <= outs_next;
      lock_cnt <= lock_next;
      for (int ch = 0; ch < 3; ch++) db_cnt[ch] <= db_cnt_next[ch];
    end
  end

  assign {Q, D, N} = outs;
  assign Busy      = (|pending) || (state != IDLE);

`ifdef COIN_TALLY_EN
  logic [7:0] coin_val;
  logic [8:0] tally_sum;

  always_comb begin
    coin_val = 8'd0;
    if (grant[2])      coin_val = 8'd25;
    else if (grant[1]) coin_val = 8'd10;
    else if (grant[0]) coin_val = 8'd5;
  end

  assign tally_sum = {1'b0, Tally} + {1'b0, coin_val};

  // Tally moves on the edge that launches the pulse, saturating at 255.
  always_ff @(posedge ClkIn) begin
    if (!Reset)            Tally <= '0;
    else if (tally_sum[8]) Tally <= 8'hFF;
    else                   Tally <= tally_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner: directed scenarios plus random button
// traffic compared against a behavioural model. Define COIN_TALLY_EN to also check Tally.
module tb_coin_input_conditioner;

  localparam int DEB  = 4;
  localparam int LOCK = 2;

  logic ClkIn = 1'b0;
  logic Reset = 1'b0;
  logic BN = 1'b0, BD = 1'b0, BQ = 1'b0;
  logic N, D, Q, Busy;
`ifdef COIN_TALLY_EN
  logic [7:0] Tally;
`endif

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .ClkIn(ClkIn),
    .Reset(Reset),
    .BN   (BN),
    .BD   (BD),
    .BQ   (BQ),
    .N    (N),
    .D    (D),
`ifdef COIN_TALLY_EN
    .Q    (Q),
    .Busy (Busy),
    .Tally(Tally)
`else
    .Q    (Q),
    .Busy (Busy)
`endif
  );

  always #5 ClkIn = ~ClkIn;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
  endtask

  // Reference model: a raw level reaches the debouncer two edges later; the debounced level
  // flips once the last DEB samples all disagree with it. Pulses may start no sooner than
  // 2+LOCK edges after the previous one.
  logic [2:0]     m_s1, m_s2, m_level, m_pend, m_out;
  logic [DEB-1:0] m_hist [3];
  bit             m_busy;
  int             m_last_grant;
  int             m_tally;

  task automatic model_edge(input logic rst, input logic [2:0] raw);
    logic [2:0] sample, rise, grant;
    edge_cnt++;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_out = '0;
      m_busy = 1'b0; m_last_grant = -1000; m_tally = 0;
      for (int ch = 0; ch < 3; ch++) m_hist[ch] = '0;
      return;
    end
    sample = m_s2;
    m_s2   = m_s1;
    m_s1   = raw;
    rise   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      m_hist[ch] = (m_hist[ch] << 1) | DEB'(sample[ch]);
      if (m_hist[ch] == {DEB{~m_level[ch]}}) begin
        m_level[ch] = ~m_level[ch];
        if (m_level[ch]) rise[ch] = 1'b1;
      end
    end
    grant = '0;
    if (m_pend != 0 && edge_cnt >= m_last_grant + 2 + LOCK) begin
      if (m_pend[2])      begin grant = 3'b100; m_tally += 25; end
      else if (m_pend[1]) begin grant = 3'b010; m_tally += 10; end
      else                begin grant = 3'b001; m_tally += 5;  end
      if (m_tally > 255) m_tally = 255;
      m_last_grant = edge_cnt;
    end
    m_pend = (m_pend & ~grant) | rise;
    m_out  = grant;
    m_busy = (m_pend != 0) || (edge_cnt < m_last_grant + 1 + LOCK);
  endtask

  int cnt_n, cnt_d, cnt_q;
  int last_n, last_d, last_q;

  task automatic clear_counts();
    cnt_n = 0; cnt_d = 0; cnt_q = 0;
    last_n = -1; last_d = -1; last_q = -1;
  endtask

  task automatic step(input logic rst, input logic [2:0] raw);
    Reset = rst;
    {BQ, BD, BN} = raw;
    @(posedge ClkIn);
    model_edge(rst, raw);
    @(negedge ClkIn);
    check("coins", {29'd0, Q, D, N}, {29'd0, m_out});
    check("busy", {31'd0, Busy}, {31'd0, m_busy});
    check("onehot", {31'd0, ($countones({Q, D, N}) <= 1)}, 32'd1);
`ifdef COIN_TALLY_EN
    check("tally", {24'd0, Tally}, m_tally);
`endif
    if (N === 1'b1) begin cnt_n++; last_n = edge_cnt; end
    if (D === 1'b1) begin cnt_d++; last_d = edge_cnt; end
    if (Q === 1'b1) begin cnt_q++; last_q = edge_cnt; end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 3'b000);
  endtask

  int first_q;
  int start_edge;

  initial begin
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000);
    check("reset_coins", {29'd0, Q, D, N}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    idle(5);

    // Clean quarter press held 20 cycles: pulse in the 7th cycle after the first sample.
    clear_counts();
    first_q = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'b100);
      if (Q === 1'b1 && first_q < 0) first_q = i + 1;
    end
    check("q_latency", first_q, 32'd7);
    check("q_count", cnt_q, 32'd1);
    idle(10);
    check("q_busy_done", {31'd0, Busy}, 32'd0);
    check("q_no_nd", cnt_n + cnt_d, 32'd0);

    // Bouncing nickel then stable high: a single pulse DEB+2 edges after it settles.
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b1, {2'b00, 1'(i % 2)});
    start_edge = edge_cnt;
    for (int i = 0; i < 15; i++) step(1'b1, 3'b001);
    check("bounce_n_count", cnt_n, 32'd1);
    check("bounce_n_delay", last_n - start_edge, DEB + 2);
    idle(12);

    // Simultaneous press: Q, then D, then N, each 2+LOCK cycles apart.
    clear_counts();
    for (int i = 0; i < 30; i++) step(1'b1, 3'b111);
    check("simul_counts", {cnt_q[7:0], cnt_d[7:0], cnt_n[7:0]}, 32'h010101);
    check("simul_qd_gap", last_d - last_q, 2 + LOCK);
    check("simul_dn_gap", last_n - last_d, 2 + LOCK);
    idle(12);

    // Three-sample dime glitch never gets through.
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b010);
    idle(12);
    check("glitch_d", cnt_d, 32'd0);

    // Reset during a dime pulse with a nickel still pending: nickel is lost.
    clear_counts();
    for (int i = 0; i < 20 && D !== 1'b1; i++) step(1'b1, 3'b011);
    check("rst_d_seen", {31'd0, D}, 32'd1);
    step(1'b0, 3'b000);
    check("rst_outs", {28'd0, Q, D, N, Busy}, 32'd0);
    clear_counts();
    idle(20);
    check("rst_no_n", cnt_n, 32'd0);

`ifdef COIN_TALLY_EN
    // Eleven quarters: 25..250, then clamped at 255.
    step(1'b0, 3'b000);
    for (int c = 0; c < 11; c++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 3'b100);
      idle(8);
    end
    check("tally_sat", {24'd0, Tally}, 32'd255);
`endif

    // Random traffic: clean presses, bounce bursts, short glitches and occasional resets.
    for (int it = 0; it < 150; it++) begin
      logic [2:0] r;
      r = 3'($urandom);
      case ($urandom_range(0, 4))
        0: idle($urandom_range(1, 10));
        1: begin
          for (int i = $urandom_range(5, 15); i > 0; i--) step(1'b1, r);
          idle($urandom_range(5, 15));
        end
        2: begin
          for (int i = $urandom_range(3, 12); i > 0; i--) step(1'b1, 3'($urandom));
          for (int i = $urandom_range(8, 15); i > 0; i--) step(1'b1, r);
        end
        3: begin
          for (int i = $urandom_range(1, 3); i > 0; i--) step(1'b1, r);
          idle($urandom_range(1, 6));
        end
        default: begin
          if ($urandom_range(0, 4) == 0) step(1'b0, r);
          else step(1'b1, r);
        end
      endcase
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
